// File: rtl/robot_pose_tracker.sv
// Pose and bookkeeping unit for the pipe-cleaning robot: row/column/orientation on a
// ROWS x COLS map, with move/turn/remove counters, a stuck detector and a sticky anomaly flag.
module robot_pose_tracker #(
  parameter int unsigned ROWS         = 10,
  parameter int unsigned COLS         = 20,
  parameter int unsigned ROW_W        = 4,
  parameter int unsigned COL_W        = 5,
  parameter int unsigned START_ROW    = 1,
  parameter int unsigned START_COL    = 1,
  parameter logic [1:0]  START_ORIENT = 2'b00,
  parameter bit          TURN_CW      = 1'b1,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned STUCK_LIMIT  = 8
) (
  input  logic             clock_50,
  input  logic             reset_key,
  input  logic             step,
  input  logic             front,
  input  logic             turn,
  input  logic             remove,
  input  logic             blocked_ahead,
  input  logic             load_pose,
  input  logic [ROW_W-1:0] load_row,
  input  logic [COL_W-1:0] load_col,
  input  logic [1:0]       load_orient,
  output logic [ROW_W-1:0] robot_row,
  output logic [COL_W-1:0] robot_column,
  output logic [1:0]       robot_orientation,
  output logic             bump,
  output logic             conflict,
  output logic             stuck,
  output logic             anomalous,
  output logic [CNT_W-1:0] move_count,
  output logic [CNT_W-1:0] turn_count,
  output logic [CNT_W-1:0] remove_count
);

  localparam int unsigned SC_W = $clog2(STUCK_LIMIT + 1);
  localparam logic [1:0] OR_N = 2'b00;
  localparam logic [1:0] OR_S = 2'b01;
  localparam logic [1:0] OR_E = 2'b10;
  localparam logic [1:0] OR_W = 2'b11;
  localparam logic [ROW_W:0]   ROW_ONE  = (ROW_W + 1)'(1);
  localparam logic [COL_W:0]   COL_ONE  = (COL_W + 1)'(1);
  localparam logic [ROW_W:0]   ROW_MAX  = (ROW_W + 1)'(ROWS);
  localparam logic [COL_W:0]   COL_MAX  = (COL_W + 1)'(COLS);
  localparam logic [SC_W-1:0]  SC_LIMIT = SC_W'(STUCK_LIMIT);
  localparam logic [SC_W-1:0]  SC_ONE   = SC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [1:0]       orient_q, orient_d;
  logic             bump_q, bump_d;
  logic             conflict_q, conflict_d;
  logic             stuck_q, stuck_d;
  logic             anom_q, anom_d;
  logic [CNT_W-1:0] move_cnt_q, move_cnt_d;
  logic [CNT_W-1:0] turn_cnt_q, turn_cnt_d;
  logic [CNT_W-1:0] rem_cnt_q, rem_cnt_d;
  logic [SC_W-1:0]  stuck_cnt_q, stuck_cnt_d;

  logic [ROW_W:0] tgt_row_s;
  logic [COL_W:0] tgt_col_s;
  logic           target_ok_s;
  logic           moved_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  function automatic logic [1:0] rotate(input logic [1:0] o);
    case (o)
      OR_N:    rotate = TURN_CW ? OR_E : OR_W;
      OR_E:    rotate = TURN_CW ? OR_S : OR_N;
      OR_S:    rotate = TURN_CW ? OR_W : OR_E;
      OR_W:    rotate = TURN_CW ? OR_N : OR_S;
      default: rotate = o;
    endcase
  endfunction

  // Target cell computed one bit wider so an off-map target is out of range instead of wrapping.
  always_comb begin
    tgt_row_s = {1'b0, row_q};
    tgt_col_s = {1'b0, col_q};
    case (orient_q)
      OR_N:    tgt_row_s = {1'b0, row_q} - ROW_ONE;
      OR_S:    tgt_row_s = {1'b0, row_q} + ROW_ONE;
      OR_E:    tgt_col_s = {1'b0, col_q} + COL_ONE;
      OR_W:    tgt_col_s = {1'b0, col_q} - COL_ONE;
      default: tgt_row_s = {1'b0, row_q};
    endcase
    target_ok_s = !blocked_ahead &&
                  (tgt_row_s >= ROW_ONE) && (tgt_row_s <= ROW_MAX) &&
                  (tgt_col_s >= COL_ONE) && (tgt_col_s <= COL_MAX);
  end

  // Step/load next-state: load beats step, turn beats front, remove counts independently.
  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    orient_d    = orient_q;
    bump_d      = 1'b0;
    conflict_d  = 1'b0;
    stuck_d     = stuck_q;
    anom_d      = anom_q;
    move_cnt_d  = move_cnt_q;
    turn_cnt_d  = turn_cnt_q;
    rem_cnt_d   = rem_cnt_q;
    stuck_cnt_d = stuck_cnt_q;
    moved_s     = 1'b0;
    if (load_pose) begin
      row_d       = load_row;
      col_d       = load_col;
      orient_d    = load_orient;
      stuck_cnt_d = '0;
      stuck_d     = 1'b0;
      anom_d      = anom_q || (load_row == '0) || ({1'b0, load_row} > ROW_MAX) ||
                    (load_col == '0) || ({1'b0, load_col} > COL_MAX);
    end else if (step) begin
      if (remove) begin
        rem_cnt_d = sat_inc(rem_cnt_q);
      end else begin
        rem_cnt_d = rem_cnt_q;
      end
      if (turn) begin
        orient_d   = rotate(orient_q);
        turn_cnt_d = sat_inc(turn_cnt_q);
        conflict_d = front;
      end else if (front) begin
        if (target_ok_s) begin
          row_d      = tgt_row_s[ROW_W-1:0];
          col_d      = tgt_col_s[COL_W-1:0];
          move_cnt_d = sat_inc(move_cnt_q);
          moved_s    = 1'b1;
        end else begin
          bump_d = 1'b1;
        end
      end else begin
        moved_s = 1'b0;
      end
      if (moved_s) begin
        stuck_cnt_d = '0;
        stuck_d     = 1'b0;
      end else begin
        if (stuck_cnt_q >= SC_LIMIT) begin
          stuck_cnt_d = SC_LIMIT;
        end else begin
          stuck_cnt_d = stuck_cnt_q + SC_ONE;
        end
        stuck_d = (stuck_cnt_d >= SC_LIMIT);
      end
    end else begin
      moved_s = 1'b0;
    end
  end

  // State registers; reset discards any command in flight.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      row_q       <= ROW_W'(START_ROW);
      col_q       <= COL_W'(START_COL);
      orient_q    <= START_ORIENT;
      bump_q      <= 1'b0;
      conflict_q  <= 1'b0;
      stuck_q     <= 1'b0;
      anom_q      <= 1'b0;
      move_cnt_q  <= '0;
      turn_cnt_q  <= '0;
      rem_cnt_q   <= '0;
      stuck_cnt_q <= '0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      orient_q    <= orient_d;
      bump_q      <= bump_d;
      conflict_q  <= conflict_d;
      stuck_q     <= stuck_d;
      anom_q      <= anom_d;
      move_cnt_q  <= move_cnt_d;
      turn_cnt_q  <= turn_cnt_d;
      rem_cnt_q   <= rem_cnt_d;
      stuck_cnt_q <= stuck_cnt_d;
    end
  end

  assign robot_row         = row_q;
  assign robot_column      = col_q;
  assign robot_orientation = orient_q;
  assign bump              = bump_q;
  assign conflict          = conflict_q;
  assign stuck             = stuck_q;
  assign anomalous         = anom_q;
  assign move_count        = move_cnt_q;
  assign turn_count        = turn_cnt_q;
  assign remove_count      = rem_cnt_q;

endmodule

// File: doc/robot_pose_tracker.md
Name: robot_pose_tracker

Overview:
- Parametrised pose and bookkeeping unit for the pipe-cleaning robot.
- Holds the robot's row, column and orientation on a ROWS x COLS map. Each step applies the controller's front, turn and remove commands. Moves into walls or barriers are refused and flagged.
- Keeps move, turn and removal counters, a stuck detector and a sticky anomaly flag. Replaces the fixed 10x20 pose logic inside world and feeds its sensor lookup.

Parameters:
- ROWS, 10, map rows; valid rows are 1..ROWS, row 1 is the northmost.
- COLS, 20, map columns; valid columns are 1..COLS, column 1 is the westmost.
- ROW_W, 4, width of row values (must hold ROWS).
- COL_W, 5, width of column values (must hold COLS).
- START_ROW, 1, row loaded at reset.
- START_COL, 1, column loaded at reset.
- START_ORIENT, 2'b00, orientation loaded at reset.
- TURN_CW, 1, 1 = turn rotates clockwise, 0 = counter-clockwise.
- CNT_W, 16, width of each counter.
- STUCK_LIMIT, 8, number of consecutive non-moving steps that raises stuck.

Ports:
- clock_50  in  1  system clock.
- reset_key  in  1  asynchronous, active-low reset.
- step  in  1  one-cycle pulse; command inputs are sampled only in this cycle.
- front  in  1  command: advance one cell.
- turn  in  1  command: rotate 90 degrees.
- remove  in  1  command: trash removed at the current cell.
- blocked_ahead  in  1  barrier or wall in the facing cell (from the map).
- load_pose  in  1  one-cycle pulse; relocates the robot.
- load_row  in  ROW_W  row to load.
- load_col  in  COL_W  column to load.
- load_orient  in  2  orientation to load.
- robot_row  out  ROW_W  current row.
- robot_column  out  COL_W  current column.
- robot_orientation  out  2  current orientation: north 00, south 01, east 10, west 11.
- bump  out  1  one-cycle pulse: a front command was refused.
- conflict  out  1  one-cycle pulse: front and turn were both high in a step.
- stuck  out  1  level: STUCK_LIMIT consecutive steps without a move.
- anomalous  out  1  sticky: pose left the legal range.
- move_count  out  CNT_W  number of successful moves.
- turn_count  out  CNT_W  number of rotations.
- remove_count  out  CNT_W  number of remove commands.

Behaviour:
- Reset (reset_key=0, asynchronous):
  - row=START_ROW, column=START_COL, orientation=START_ORIENT.
  - All counters 0; bump, conflict, stuck and anomalous all 0.
  - Reset takes effect mid-step and discards the pending command.
- All outputs are registered. A step sampled at edge N is visible after edge N. The bump and conflict pulses last exactly one cycle.
- Target cell for front:
  - north: row-1.
  - south: row+1.
  - east: column+1.
  - west: column-1.
  - Arithmetic is done at width+1 so an off-map target never wraps.
- Step priority:
  1. load_pose. If load_pose and step are high together, the load wins and the step is dropped entirely (no counts).
  2. turn. If front is also high: rotate only, pulse conflict, ignore front.
  3. front. If blocked_ahead=1 or the target is outside 1..ROWS / 1..COLS: pose unchanged, pulse bump. Otherwise move to the target and increment move_count.
- Rotation:
  - TURN_CW=1: N->E->S->W->N.
  - TURN_CW=0: the reverse order.
  - Each rotation increments turn_count.
- remove is independent of motion: it increments remove_count even when combined with turn or front.
- Counters saturate at all-ones and never wrap.
- Stuck detector:
  - An internal count of consecutive steps without a successful move. Turns, bumps and idle steps (no command) all count.
  - A successful move or a load clears the count and stuck.
  - stuck asserts on the step whose count reaches STUCK_LIMIT, then holds, with the count saturating, until cleared.
- Load:
  - Pose takes load_row, load_col and load_orient unconditionally.
  - If the loaded row or column is 0 or beyond ROWS/COLS, anomalous is set.
  - anomalous clears only on reset.
- Step with no command: pose unchanged, stuck count advances, no pulses.

Test Plan:
- Reset check: hold reset_key=0, then release. Required: row=1, column=1, orientation=00, all counters 0, all flags 0, including after one idle clock.
- North-edge bump: step with front=1, facing north at (1,1). Required: pose stays (1,1), bump high for exactly one cycle, move_count=0. Then turn, turn (now south) and front. Required: row=2, move_count=1, turn_count=2.
- Rotation order: four steps with turn=1 and TURN_CW=1. Required: orientation 10, 01, 11, 00. Repeat with TURN_CW=0. Required: 11, 01, 10, 00.
- Conflict and remove: step with front=1, turn=1, remove=1, facing east at (5,5). Required: orientation=01, position (5,5), conflict pulse, remove_count=1, move_count unchanged.
- Barrier and stuck: eight front steps with blocked_ahead=1. Required: eight bumps and stuck=1 after the 8th. Then a free front step. Required: stuck=0, move_count incremented.
- Load and reset: load_pose with (11,3,00) on the default 10x20 map. Required: row=11, anomalous=1. Then assert reset_key=0 mid-step. Required: immediate return to (1,1,north) with anomalous=0.
